data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the per-thread data memory read/write channels that a core's LSUs drive as initiators.
- Serves NUM_CHANNELS independent channels from one local single-port data array, using a four-phase valid/ready handshake.
- Round-robin arbitration across channels; one array access per cycle.
- Sits between a dual-warp core, or a cache front end, and on-chip data storage.

Parameters:
- NUM_CHANNELS, 8: number of read+write channel pairs served (e.g. 2 warps x 4 threads).
- ADDR_BITS, 8: data address width; array depth is 2**ADDR_BITS.
- DATA_BITS, 8: data word width.
- LATENCY, 2: cycles from array grant to ready assertion; legal range 1..7.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_valid  in  [NUM_CHANNELS]  per-channel read request.
- read_address  in  [NUM_CHANNELS][ADDR_BITS]  read address; initiator holds it while valid is high.
- read_ready  out  [NUM_CHANNELS]  read data valid / acknowledge.
- read_data  out  [NUM_CHANNELS][DATA_BITS]  read data; stable while read_ready is high.
- write_valid  in  [NUM_CHANNELS]  per-channel write request.
- write_address  in  [NUM_CHANNELS][ADDR_BITS]  write address; held while valid is high.
- write_data  in  [NUM_CHANNELS][DATA_BITS]  write data; held while valid is high.
- write_ready  out  [NUM_CHANNELS]  write acknowledge.
- busy  out  1  high when any channel is not in IDLE.

Behaviour:
- Reset, asynchronous and immediate:
  - read_ready = 0, write_ready = 0, read_data = 0, busy = 0.
  - All channel FSMs go to IDLE.
  - Round-robin pointer = 0.
  - Latency counters = 0.
  - Array contents are not reset and are retained across reset.
- Per-channel FSM states: IDLE, PENDING, WAITING, RELAYING.
  - IDLE -> PENDING: read_valid or write_valid high. If both are high in the same cycle, the read is taken and the write stays pending; the write is served after the read handshake completes.
  - PENDING -> WAITING: channel wins arbitration. The array access happens in the grant cycle:
    - Write: array[address] <= write_data.
    - Read: data is captured into the channel's read_data register.
  - WAITING: counter runs LATENCY-1 cycles. Then assert ready and go to RELAYING.
    - With LATENCY=1, ready rises the cycle after the grant.
    - Overall, ready is first seen high LATENCY cycles after the grant edge.
  - RELAYING: ready held high until the matching valid is sampled low. In that cycle ready <= 0 and the FSM goes to IDLE. A new request is accepted no earlier than the following cycle.
- Arbitration:
  - Each cycle, at most one PENDING channel is granted.
  - Search starts at the pointer and wraps modulo NUM_CHANNELS.
  - After a grant, the pointer = granted index + 1, wrapping NUM_CHANNELS-1 -> 0.
  - No grant: pointer unchanged.
  - Worst-case wait for a pending channel is NUM_CHANNELS-1 grants.
- Same-address interactions:
  - A read granted in the cycle after a write grant to the same address returns the new data.
  - Accesses are strictly serialized by grant order, so there are no same-cycle hazards.
- Initiator protocol error: valid dropped while PENDING or WAITING.
  - The request is still completed.
  - Ready is asserted, then removed on the next cycle because valid is low.
  - The FSM returns to IDLE; no lockup.
- read_data holds its last value after ready falls.
- busy = OR over channels of (state != IDLE).

Optional Feature:
- Macro: DATA_MEM_RESP_STATS_EN.
- Defined:
  - Adds outputs read_count[15:0] and write_count[15:0].
  - Each counter increments on every read or write grant respectively and saturates at 16'hFFFF.
  - Both clear on reset.
  - Adds a clr_stats input (1 bit, synchronous) that zeroes both counters; clear wins over a same-cycle increment.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Single write then read, LATENCY=2: ch0 write addr 0x10 data 0xA5; write_ready rises 2 cycles after grant; drop valid -> ready low next cycle. Then ch0 read 0x10 -> read_data=0xA5 with read_ready.
- Full contention: all 8 channels assert read in the same cycle, addresses 0..7 preloaded with 0x30+i. Grants go in order ch0..ch7, one per cycle; read_ready[i] rises at cycle i+LATENCY; each read_data[i] = 0x30+i.
- Round-robin fairness: ch3 and ch5 re-request continuously for 20 grants -> grants alternate 3,5,3,5; neither channel waits more than 1 extra grant.
- Simultaneous read+write on ch2, addr 0x40, old data 0x11, write data 0x22 -> read completes first returning 0x11; the write follows; a later read returns 0x22.
- Reset mid-operation: assert reset while ch1 is WAITING and ch4 is RELAYING -> all ready drop immediately, busy=0. After release, a read of a previously written address returns the stored value.
- Stats (macro defined): 3 writes + 5 reads -> write_count=3, read_count=5; clr_stats pulse -> both 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-channel read/write responder over one single-port data array, round-robin granted.
// Defining DATA_MEM_RESP_STATS_EN adds saturating read/write grant counters with a sync clear.
module data_mem_responder #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int LATENCY      = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0]                 read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [NUM_CHANNELS-1:0]                 read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [NUM_CHANNELS-1:0]                 write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [NUM_CHANNELS-1:0]                 write_ready,
  output logic                                    busy
`ifdef DATA_MEM_RESP_STATS_EN
  ,
  input  logic                                    clr_stats,
  output logic [15:0]                             read_count,
  output logic [15:0]                             write_count
`endif
);

  // Handshake: four-phase. The initiator raises valid and holds address/data; ready rises
  // LATENCY cycles after the array grant and stays high until valid is sampled low, then
  // drops on that edge. A read seen together with a write is served first.

  localparam int PTR_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [2:0] LAT_LAST = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, PENDING, WAITING, RELAYING} chan_state_t;

  chan_state_t                 state      [NUM_CHANNELS];
  chan_state_t                 state_next [NUM_CHANNELS];
  logic [2:0]                  lat_cnt      [NUM_CHANNELS];
  logic [2:0]                  lat_cnt_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]     is_write, is_write_next;
  logic [NUM_CHANNELS-1:0]     pending, grant, active;
  logic [PTR_BITS-1:0]         rr_ptr, grant_idx;
  logic                        grant_any;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pending[i]     = (state[i] == PENDING);
      active[i]      = (state[i] != IDLE);
      read_ready[i]  = (state[i] == RELAYING) && !is_write[i];
      write_ready[i] = (state[i] == RELAYING) && is_write[i];
    end
  end

  assign busy = |active;

  // First pending channel at or after the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!grant_any && pending[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
        grant_any = 1'b1;
        grant_idx = PTR_BITS'((int'(rr_ptr) + k) % NUM_CHANNELS);
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      grant[i] = grant_any && (grant_idx == PTR_BITS'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_next[i]    = state[i];
      lat_cnt_next[i]  = lat_cnt[i];
      is_write_next[i] = is_write[i];
      unique case (state[i])
        IDLE: begin
          if (read_valid[i]) begin
            state_next[i]    = PENDING;
            is_write_next[i] = 1'b0;
          end else if (write_valid[i]) begin
            state_next[i]    = PENDING;
            is_write_next[i] = 1'b1;
          end
        end
        PENDING: begin
          if (grant[i]) begin
            state_next[i]   = WAITING;
            lat_cnt_next[i] = '0;
          end
        end
        WAITING: begin
          if (lat_cnt[i] == LAT_LAST) state_next[i] = RELAYING;
          else                        lat_cnt_next[i] = lat_cnt[i] + 3'd1;
        end
        RELAYING: begin
          // A valid dropped early still lands here; it simply releases after one cycle.
          if (!(is_write[i] ? write_valid[i] : read_valid[i])) state_next[i] = IDLE;
        end
        default: state_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]   <= IDLE;
        lat_cnt[i] <= '0;
      end
      is_write  <= '0;
      rr_ptr    <= '0;
      read_data <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i]   <= state_next[i];
        lat_cnt[i] <= lat_cnt_next[i];
      end
      is_write <= is_write_next;
      if (grant_any) begin
        rr_ptr <= (int'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + 1'b1;
        if (!is_write[grant_idx])
          read_data[grant_idx] <= mem[read_address[grant_idx]];
      end
    end
  end

  // Array contents survive reset, so this port carries no reset.
  always_ff @(posedge clk) begin
    if (grant_any && is_write[grant_idx])
      mem[write_address[grant_idx]] <= write_data[grant_idx];
  end

`ifdef DATA_MEM_RESP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (clr_stats) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (grant_any) begin
      if (!is_write[grant_idx] && read_count != 16'hFFFF)
        read_count <= read_count + 16'd1;
      if (is_write[grant_idx] && write_count != 16'hFFFF)
        write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic
// checked against a plain memory model and an expected-read queue.
module tb_data_mem_responder;

  localparam int NCH = 8;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]         rv, rr, wv, wr;
  logic [NCH-1:0][AW-1:0] ra, wa;
  logic [NCH-1:0][DW-1:0] rd, wd;
  logic                   busy;
`ifdef DATA_MEM_RESP_STATS_EN
  logic                   clr_stats;
  logic [15:0]            rcount, wcount;
`endif

  data_mem_responder #(
    .NUM_CHANNELS(NCH), .ADDR_BITS(AW), .DATA_BITS(DW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(rv), .read_address(ra), .read_ready(rr), .read_data(rd),
    .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr),
    .busy(busy)
`ifdef DATA_MEM_RESP_STATS_EN
    , .clr_stats(clr_stats), .read_count(rcount), .write_count(wcount)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rv = '0; wv = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Full four-phase transaction on one channel; lat counts edges from request to ready.
  task automatic do_access(input int ch, input bit is_w, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output logic [DW-1:0] rdata,
                           output int lat);
    if (is_w) begin
      wa[ch] = addr; wd[ch] = data; wv[ch] = 1'b1;
    end else begin
      ra[ch] = addr; rv[ch] = 1'b1;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(is_w ? wr[ch] : rr[ch]) && lat < 100);
    checks++;
    if (!(is_w ? wr[ch] : rr[ch])) begin
      errors++;
      $display("FAIL handshake_timeout ch%0d: ready=0 after %0d cycles, want 1", ch, lat);
    end
    rdata = rd[ch];
    if (is_w) begin
      wv[ch] = 1'b0;
      mem_model[addr] = data;
    end else begin
      rv[ch] = 1'b0;
    end
    tick();
    checks++;
    if ((is_w ? wr[ch] : rr[ch]) !== 1'b0) begin
      errors++;
      $display("FAIL ready_release ch%0d: ready=%b one cycle after valid low, want 0", ch,
               is_w ? wr[ch] : rr[ch]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rr !== '0) begin errors++; $display("FAIL reset_read_ready got %h want 0", rr); end
    checks++;
    if (wr !== '0) begin errors++; $display("FAIL reset_write_ready got %h want 0", wr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL reset_read_data got %h want 0", rd); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write_read();
    logic [DW-1:0] r;
    int lat;
    do_access(0, 1'b1, 8'h10, 8'hA5, r, lat);
    checks++;
    if (lat != LAT + 2) begin errors++; $display("FAIL write_latency got %0d want %0d", lat, LAT + 2); end
    do_access(0, 1'b0, 8'h10, 8'h00, r, lat);
    checks++;
    if (lat != LAT + 2) begin errors++; $display("FAIL read_latency got %0d want %0d", lat, LAT + 2); end
    checks++;
    if (r !== 8'hA5) begin errors++; $display("FAIL single_read_data got %h want a5", r); end
    checks++;
    if (rd[0] !== 8'hA5) begin errors++; $display("FAIL read_data_hold got %h want a5", rd[0]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_full_contention();
    logic [DW-1:0] r;
    logic [DW-1:0] got [NCH];
    int first [NCH];
    int lat, n, seen;
    for (int i = 0; i < NCH; i++) do_access(i, 1'b1, AW'(i), DW'(8'h30 + i), r, lat);
    apply_reset();
    for (int i = 0; i < NCH; i++) begin
      ra[i] = AW'(i);
      first[i] = -1;
    end
    rv = '1;
    n = 0;
    seen = 0;
    while (seen < NCH && n < 60) begin
      tick();
      n++;
      for (int i = 0; i < NCH; i++) begin
        if (rr[i] && first[i] < 0) begin
          first[i] = n;
          got[i] = rd[i];
          seen++;
        end
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL contention_busy got %b want 1", busy); end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (first[i] != i + 2 + LAT) begin
        errors++;
        $display("FAIL contention_ready_cycle ch%0d got %0d want %0d", i, first[i], i + 2 + LAT);
      end
      checks++;
      if (first[i] >= 0 && got[i] !== mem_model[i]) begin
        errors++;
        $display("FAIL contention_data ch%0d got %h want %h", i, got[i], mem_model[i]);
      end
    end
    rv = '0;
    tick();
    checks++;
    if (rr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_release ready=%h busy=%b want 0/0", rr, busy);
    end
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] r, exp;
    logic [AW-1:0] addr;
    int lat, ch;
    bit is_w;
    for (int a = 0; a < 16; a++)
      do_access($urandom_range(0, NCH - 1), 1'b1, AW'(8'h80 + a), DW'($urandom), r, lat);
    for (int t = 0; t < 24; t++) begin
      ch = $urandom_range(0, NCH - 1);
      is_w = 1'($urandom_range(0, 1));
      addr = AW'(8'h80 + $urandom_range(0, 15));
      if (!is_w) exp_q.push_back(mem_model[addr]);
      do_access(ch, is_w, addr, DW'($urandom), r, lat);
      checks++;
      if (lat != LAT + 2) begin errors++; $display("FAIL random_latency ch%0d got %0d want %0d", ch, lat, LAT + 2); end
      if (!is_w) begin
        exp = exp_q.pop_front();
        checks++;
        if (r !== exp) begin errors++; $display("FAIL random_read ch%0d addr %h got %h want %h", ch, addr, r, exp); end
      end
    end
  endtask

  task automatic test_fairness();
    int chs [2] = '{3, 5};
    logic [DW-1:0] fexp [NCH];
    int order [$];
    int issued, n, c;
    logic [AW-1:0] addr;
    apply_reset();
    issued = 0;
    n = 0;
    while (order.size() < 20 && n < 400) begin
      for (int j = 0; j < 2; j++) begin
        c = chs[j];
        if (rv[c] && rr[c]) begin
          order.push_back(c);
          checks++;
          if (rd[c] !== fexp[c]) begin errors++; $display("FAIL fair_data ch%0d got %h want %h", c, rd[c], fexp[c]); end
          rv[c] = 1'b0;
        end else if (!rv[c] && !rr[c] && issued < 20) begin
          addr = AW'(8'h80 + $urandom_range(0, 15));
          ra[c] = addr;
          fexp[c] = mem_model[addr];
          rv[c] = 1'b1;
          issued++;
        end
      end
      tick();
      n++;
    end
    rv = '0;
    tick();
    checks++;
    if (order.size() != 20) begin errors++; $display("FAIL fair_count got %0d want 20", order.size()); end
    checks++;
    if (order.size() > 0 && order[0] != 3) begin errors++; $display("FAIL fair_first got %0d want 3", order[0]); end
    for (int k = 1; k < order.size(); k++) begin
      checks++;
      if (order[k] == order[k-1]) begin
        errors++;
        $display("FAIL fair_alternate grant %0d got ch%0d twice, want other channel", k, order[k]);
      end
    end
  endtask

  task automatic test_simultaneous_rw();
    logic [DW-1:0] r;
    int lat, n;
    do_access(2, 1'b1, 8'h40, 8'h11, r, lat);
    ra[2] = 8'h40; wa[2] = 8'h40; wd[2] = 8'h22;
    rv[2] = 1'b1; wv[2] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rr[2] && n < 50);
    checks++;
    if (rd[2] !== 8'h11 || rr[2] !== 1'b1) begin
      errors++;
      $display("FAIL simul_read_first ready=%b data=%h want 1/11", rr[2], rd[2]);
    end
    checks++;
    if (wr[2] !== 1'b0) begin errors++; $display("FAIL simul_write_ready_early got %b want 0", wr[2]); end
    rv[2] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!wr[2] && n < 50);
    checks++;
    if (wr[2] !== 1'b1) begin errors++; $display("FAIL simul_write_done got %b want 1", wr[2]); end
    wv[2] = 1'b0;
    mem_model[8'h40] = 8'h22;
    tick();
    do_access(2, 1'b0, 8'h40, 8'h00, r, lat);
    checks++;
    if (r !== 8'h22) begin errors++; $display("FAIL simul_readback got %h want 22", r); end
  endtask

  task automatic test_protocol_error();
    logic [DW-1:0] r, d;
    int n, high;
    d = DW'($urandom);
    wa[6] = 8'h55; wd[6] = d; wv[6] = 1'b1;
    tick();
    wv[6] = 1'b0;
    mem_model[8'h55] = d;
    n = 0;
    high = 0;
    while (n < 20) begin
      tick();
      n++;
      if (wr[6]) high++;
    end
    checks++;
    if (high != 1) begin errors++; $display("FAIL early_drop_ready_cycles got %0d want 1", high); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL early_drop_busy got %b want 0", busy); end
    do_access(6, 1'b0, 8'h55, 8'h00, r, n);
    checks++;
    if (r !== d) begin errors++; $display("FAIL early_drop_write_landed got %h want %h", r, d); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r;
    int n, lat;
    ra[4] = 8'h10; rv[4] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rr[4] && n < 50);
    ra[1] = 8'h80; rv[1] = 1'b1;
    tick();
    tick();
    checks++;
    if (rr[1] !== 1'b0 || rr[4] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup rr1=%b rr4=%b want 0/1", rr[1], rr[4]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rr !== '0 || wr !== '0) begin errors++; $display("FAIL midreset_ready rr=%h wr=%h want 0", rr, wr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    rv = '0; wv = '0;
    tick();
    reset = 1'b0;
    tick();
    do_access(4, 1'b0, 8'h10, 8'h00, r, lat);
    checks++;
    if (r !== mem_model[8'h10]) begin errors++; $display("FAIL midreset_retain got %h want %h", r, mem_model[8'h10]); end
  endtask

`ifdef DATA_MEM_RESP_STATS_EN
  task automatic test_stats();
    logic [DW-1:0] r;
    int lat;
    apply_reset();
    checks++;
    if (rcount !== 16'd0 || wcount !== 16'd0) begin
      errors++; $display("FAIL stats_reset got r=%0d w=%0d want 0/0", rcount, wcount);
    end
    for (int i = 0; i < 3; i++) do_access(i, 1'b1, AW'(8'hA0 + i), DW'($urandom), r, lat);
    for (int i = 0; i < 5; i++) do_access(i, 1'b0, AW'(8'hA0 + (i % 3)), 8'h00, r, lat);
    checks++;
    if (wcount !== 16'd3) begin errors++; $display("FAIL stats_write_count got %0d want 3", wcount); end
    checks++;
    if (rcount !== 16'd5) begin errors++; $display("FAIL stats_read_count got %0d want 5", rcount); end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (rcount !== 16'd0 || wcount !== 16'd0) begin
      errors++; $display("FAIL stats_clear got r=%0d w=%0d want 0/0", rcount, wcount);
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
`ifdef DATA_MEM_RESP_STATS_EN
    clr_stats = 1'b0;
`endif
    test_reset();
    test_single_write_read();
    test_full_contention();
    test_random_traffic();
    test_fairness();
    test_simultaneous_rw();
    test_protocol_error();
    test_reset_mid();
`ifdef DATA_MEM_RESP_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
